// File: rtl/ct_mul_fifo_taint.sv
// Multi-cycle multiplier with an optional zero-operand fast path, feeding a FWFT result FIFO.
// Each entry carries data taint; a sticky timing-taint bit covers the handshake outputs.
module ct_mul_fifo_taint #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned BUF_DEPTH   = 4,
  parameter int unsigned FAST_ZERO   = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic                               in_valid_t,
  output logic                               in_ready,
  output logic                               in_ready_t,
  input  logic [WIDTH-1:0]                   in_a,
  input  logic                               in_a_t,
  input  logic [WIDTH-1:0]                   in_b,
  input  logic                               in_b_t,
  input  logic                               ct_mode,
  input  logic                               ct_mode_t,
  output logic                               out_valid,
  output logic                               out_valid_t,
  input  logic                               out_ready,
  input  logic                               out_ready_t,
  output logic [2*WIDTH-1:0]                 out_result,
  output logic                               out_result_t,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     count,
  output logic                               count_t
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned LatW = $clog2(MUL_LATENCY + 1);
  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam bit          FastZero = (FAST_ZERO != 0);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            r_state, w_state_next;
  logic [LatW-1:0]   r_cnt, w_cnt_next;
  logic [PW-1:0]     r_prod;
  logic              r_ct, r_zero, r_ptaint, r_timing_t;
  logic [PtrW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [CntW-1:0]   r_count;
  logic [PW-1:0]     r_last;
  logic [PW-1:0]     r_mem [BUF_DEPTH];
  logic              r_mem_t [BUF_DEPTH];

  logic              w_accept, w_finish, w_push, w_pop, w_full;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BUF_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign in_ready  = (r_state == StIdle);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_full    = (r_count == CntW'(BUF_DEPTH));
  // Fast path is only taken on the first BUSY cycle and never under a latched ct request.
  assign w_finish  = (r_state == StBusy) &&
                     ((r_cnt == LatW'(MUL_LATENCY)) ||
                      ((r_cnt == LatW'(1)) && FastZero && !r_ct && r_zero));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_push       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = StBusy;
          w_cnt_next   = LatW'(1);
        end
      end
      StBusy: begin
        if (w_finish) begin
          if (!w_full || w_pop) begin
            w_push       = 1'b1;
            w_state_next = StIdle;
          end
        end else begin
          w_cnt_next = r_cnt + LatW'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_prod     <= '0;
      r_ct       <= 1'b0;
      r_zero     <= 1'b0;
      r_ptaint   <= 1'b0;
      r_timing_t <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_prod   <= PW'(in_a) * PW'(in_b);
        r_ct     <= ct_mode;
        r_zero   <= (in_a == '0) || (in_b == '0);
        r_ptaint <= in_a_t || in_b_t;
      end
      // Sticky: set whenever the schedule may have depended on tainted data.
      if (in_valid_t || (out_ready_t && out_valid) ||
          (w_accept && ct_mode_t) ||
          (w_accept && (in_a_t || in_b_t) && FastZero && !ct_mode)) begin
        r_timing_t <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]   <= r_prod;
      r_mem_t[r_wr_ptr] <= r_ptaint;
    end
  end

  assign out_result   = out_valid ? r_mem[r_rd_ptr] : r_last;
  assign out_result_t = out_valid && r_mem_t[r_rd_ptr];
  assign count        = r_count;
  assign in_ready_t   = r_timing_t;
  assign out_valid_t  = r_timing_t;
  assign count_t      = r_timing_t;

endmodule

// File: doc/ct_mul_fifo_taint.md
Name: ct_mul_fifo_taint

Overview:
- Taint-tracked multiplier followed by a result FIFO, with valid/ready handshakes on both sides.
- Successor to the single-slot multiply-then-buffer pair. Adds parametrised width, latency and FIFO depth.
- Adds a runtime constant-time mode that disables the zero-operand fast path.
- Taint is precise per FIFO entry for data. Timing taint on the control outputs stays 0 whenever the schedule cannot depend on tainted operands.

Parameters:
- WIDTH, 4, operand width; product is 2*WIDTH bits.
- MUL_LATENCY, 3, cycles in BUSY for a normal multiply; must be >= 2.
- BUF_DEPTH, 4, number of FIFO entries; must be >= 1.
- FAST_ZERO, 1, when 1 a zero operand finishes after 1 BUSY cycle, unless ct_mode is latched.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- in_valid  in  1  operand handshake valid
- in_valid_t  in  1  taint of in_valid
- in_ready  out  1  multiplier can accept
- in_ready_t  out  1  taint of in_ready
- in_a  in  WIDTH  operand A
- in_a_t  in  1  taint of in_a
- in_b  in  WIDTH  operand B
- in_b_t  in  1  taint of in_b
- ct_mode  in  1  constant-time request, sampled at accept
- ct_mode_t  in  1  taint of ct_mode
- out_valid  out  1  FIFO non-empty
- out_valid_t  out  1  taint of out_valid
- out_ready  in  1  consumer pop
- out_ready_t  in  1  taint of out_ready
- out_result  out  2*WIDTH  FIFO head product
- out_result_t  out  1  taint of FIFO head entry
- count  out  clog2(BUF_DEPTH+1)  FIFO occupancy
- count_t  out  1  taint of count

Behaviour:
- Reset values: state IDLE, cnt 0, FIFO empty (count 0, out_valid 0). out_result 0, out_result_t 0, timing_t 0, in_ready 1. All taint outputs 0.
- Reset mid-operation aborts the in-flight multiply and empties the FIFO.
- Multiplier FSM has states IDLE and BUSY.
  - in_ready = (state==IDLE).
  - Accept = in_valid && in_ready at a clock edge.
  - On accept, latch a*b (full 2*WIDTH product, no truncation), ct = ct_mode, and entry taint in_a_t||in_b_t.
  - On accept, set cnt=1 and go to BUSY.
- BUSY finishes when cnt==MUL_LATENCY, or when cnt==1 && FAST_ZERO && !ct && (a==0 || b==0).
  - If not finished, cnt increments.
- On finish, push product and entry taint into the FIFO and return to IDLE.
  - If the FIFO is full and no pop occurs this cycle, stay in BUSY with cnt held; push on the first cycle space exists.
  - Push while full is allowed when a pop happens in the same cycle.
- Latency: accept at edge E. Normal result is visible at out_valid MUL_LATENCY edges after E, if no backpressure. Fast-path result is visible 1 edge after E.
  - The next accept is possible on the edge after the push.
- FIFO:
  - First-word-fall-through; out_result is the head entry.
  - Pop = out_valid && out_ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers wrap modulo BUF_DEPTH.
  - When empty, out_result holds the last value and out_result_t is 0.
- Timing taint (timing_t) is a sticky register, cleared only by reset. It is set at an edge when any of these hold:
  - in_valid_t is 1;
  - out_ready_t && out_valid;
  - an accept occurs with ct_mode_t;
  - an accept occurs with (in_a_t || in_b_t) && FAST_ZERO && !ct_mode.
- Taint outputs:
  - in_ready_t = out_valid_t = count_t = timing_t.
  - out_result_t = head entry taint.
- Constant-time mode with untainted ct_mode keeps timing_t at 0 even for tainted operands.

Test Plan:
- Reset, then a=3, b=5, ct=0, all taints 0 -> out_valid at accept+3, out_result=15, count 1, all taint outputs 0.
- a=0, b=7, FAST_ZERO=1, ct=0 -> out_valid at accept+1, result 0. Repeat with ct=1 -> out_valid at accept+3.
- a=9 with in_a_t=1, ct=1 -> out_result=product, out_result_t=1, out_valid_t stays 0. Same with ct=0 -> out_valid_t=1 from the next edge onward, sticky until rst.
- BUF_DEPTH=2, out_ready=0, issue 3 multiplies -> count reaches 2, multiplier stalls in BUSY with in_ready=0. Raise out_ready for 1 cycle -> pop and push in the same cycle, count stays 2, FIFO order preserved.
- a=15, b=15, WIDTH=4 -> out_result=225 (8'hE1), no truncation. Pop 5 entries through BUF_DEPTH=4 -> pointer wrap yields correct order.
- Assert rst while BUSY with 2 entries queued -> next cycle count 0, out_valid 0, in_ready 1, all taints 0.
